// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush strobes for load-use, EX redirect and memory waits.
// Optional HAZARD_PERF_EN adds stall-cycle and redirect-flush performance counters.
module hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        ex_rd,
    input  logic              ex_re_mem,
    input  logic              ex_redirect,
    input  logic              imem_busy,
    input  logic              dmem_busy,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_stall,
    output logic              id_ex_flush,
    output logic              ex_mem_stall,
    output logic              mem_wb_flush,
`ifdef HAZARD_PERF_EN
    output logic [63:0]       perf_stall_cyc,
    output logic [63:0]       perf_flush_cnt,
`endif
    output logic              mem_timeout
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        FETCH_WAIT,
        SQUASH
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

    state_t           state;
    state_t           state_nx;
    logic             squash_pend;
    logic             squash_pend_nx;
    logic [CNT_W-1:0] wait_cnt;
    logic             load_use;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             squashing;
    logic             any_busy;

    assign rs1_hit   = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit   = id_use_rs2 && (id_rs2 == ex_rd);
    assign load_use  = ex_re_mem && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    assign any_busy  = imem_busy || dmem_busy;

    // A pending squash survives a data-memory freeze and resumes once dmem_busy drops.
    assign squashing = (state == SQUASH) || ((state == MEM_WAIT) && squash_pend);

    always_comb begin
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_stall    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_stall   = 1'b0;
        mem_wb_flush   = 1'b0;
        state_nx       = state;
        squash_pend_nx = squash_pend;

        if (rst) begin
            state_nx       = RUN;
            squash_pend_nx = 1'b0;
        end else if (dmem_busy) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
            state_nx     = MEM_WAIT;
        end else if (ex_redirect) begin
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            squash_pend_nx = imem_busy;
            state_nx       = imem_busy ? SQUASH : RUN;
        end else if (squashing) begin
            // ID holds a bubble throughout a squash, so load-use is not evaluated here.
            if_id_flush = 1'b1;
            if (imem_busy) begin
                pc_stall = 1'b1;
                state_nx = SQUASH;
            end else begin
                squash_pend_nx = 1'b0;
                state_nx       = RUN;
            end
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            state_nx    = imem_busy ? FETCH_WAIT : RUN;
        end else if (imem_busy) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
            state_nx    = FETCH_WAIT;
        end else begin
            state_nx = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            squash_pend <= 1'b0;
        end else begin
            state       <= state_nx;
            squash_pend <= squash_pend_nx;
        end
    end

    // Counts consecutive cycles with either memory busy; the first busy cycle past MAX_WAIT trips the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (any_busy) begin
            if (wait_cnt == WAIT_LIM) begin
                mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pc_stall) begin
                perf_stall_cyc <= perf_stall_cyc + 64'd1;
            end
            if (id_ex_flush && ex_redirect) begin
                perf_flush_cnt <= perf_flush_cnt + 64'd1;
            end
        end
    end
`endif

    a_if_id_excl: assert property (@(posedge clk) disable iff (rst) !(if_id_stall && if_id_flush));
    a_id_ex_excl: assert property (@(posedge clk) disable iff (rst) !(id_ex_stall && id_ex_flush));

endmodule
